mdu_ctrl_resp: RTL



---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_arith.sv | 55 +++++
 rtl/mdu_ctrl_resp.sv | 116 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide responder: op codes, sequencer states, divide-by-zero quotient.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_long_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO results for mult/multu/div/divu from the latched operands.
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so that 0x80000000 / -1 never overflows.
    assign sgn_div = (op == MD_DIV);
    assign a_mag   = (sgn_div && a[31]) ? (~a + 32'd1) : a;
    assign b_mag   = (sgn_div && b[31]) ? (~b + 32'd1) : b;
    assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (sgn_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = (sgn_div && a[31]) ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    hi_res = a;
                    lo_res = DIV0_QUOT;
                end else begin
                    hi_res = rem;
                    lo_res = quot;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl_resp.sv
// Multiply/divide responder in EX: owns HI/LO, sequences multi-cycle ops, stalls the pipe while busy.
//   state | meaning
//   IDLE  | accepts ops; mthi/mtlo write in one cycle, mfhi/mflo read combinationally
//   RUN   | down-counter running on latched op/operands; HI/LO written when it reaches 1
module mdu_ctrl_resp
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    md_op_e           op_in;

    assign op_in = md_op_e'(md_op);

    mdu_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (arith_hi),
        .lo_res (arith_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (md_valid) begin
                    if (is_long_op(op_in)) begin
                        op_d    = op_in;
                        a_d     = rs_data;
                        b_d     = rt_data;
                        cnt_d   = (op_in == MD_MULT || op_in == MD_MULTU) ?
                                  CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d = RUN;
                    end else if (op_in == MD_MTHI) begin
                        hi_d = rs_data;
                    end else if (op_in == MD_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = arith_hi;
                    lo_d    = arith_lo;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        md_rdata = 32'd0;
        if (op_in == MD_MFHI)      md_rdata = hi_q;
        else if (op_in == MD_MFLO) md_rdata = lo_q;
    end

    assign busy     = (state_q == RUN);
    assign md_stall = md_valid & busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
